// File: rtl/tile_pkg.sv
// Shared definitions for the tile scheduler: default coordinate width,
// FSM state encoding and a popcount helper for the evaluator done pulses.
package tile_pkg;

    localparam int TILE_COORD_W = 10;
    localparam int MAX_EVAL     = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        DRAIN    = 2'd2
    } state_t;

    // Number of set bits in a (zero-extended) evaluator bit vector.
    function automatic logic [3:0] popcount(input logic [MAX_EVAL-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < MAX_EVAL; i++) begin
            n = n + 4'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/tile_scheduler_if.sv
// Bundle of the triangle-in, tile-dispatch-out and completion signals.
// The scheduler uses the slave view; triangle setup plus the evaluator
// array together form the master view.
interface tile_scheduler_if #(
    parameter int COORD_W  = 10,
    parameter int NUM_EVAL = 2,
    parameter int TRI_ID_W = 8
);

    logic                tri_valid;
    logic                tri_ready;
    logic [TRI_ID_W-1:0] tri_id;
    logic [COORD_W-1:0]  bb_min_x;
    logic [COORD_W-1:0]  bb_min_y;
    logic [COORD_W-1:0]  bb_max_x;
    logic [COORD_W-1:0]  bb_max_y;
    logic [NUM_EVAL-1:0] disp_valid;
    logic [NUM_EVAL-1:0] disp_ready;
    logic [COORD_W-1:0]  disp_tile_x;
    logic [COORD_W-1:0]  disp_tile_y;
    logic [TRI_ID_W-1:0] disp_tri_id;
    logic [NUM_EVAL-1:0] eval_done;
    logic                tri_done;
    logic [TRI_ID_W-1:0] tri_done_id;
    logic                busy;

    modport master (
        output tri_valid, tri_id, bb_min_x, bb_min_y, bb_max_x, bb_max_y,
               disp_ready, eval_done,
        input  tri_ready, disp_valid, disp_tile_x, disp_tile_y, disp_tri_id,
               tri_done, tri_done_id, busy
    );

    modport slave (
        input  tri_valid, tri_id, bb_min_x, bb_min_y, bb_max_x, bb_max_y,
               disp_ready, eval_done,
        output tri_ready, disp_valid, disp_tile_x, disp_tile_y, disp_tri_id,
               tri_done, tri_done_id, busy
    );

endinterface

// File: rtl/tile_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found
// scanning upward from one past the last grant, wrapping at NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] grant
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;
    logic             found;

    // Rotating priority scan; the first hit after the last grant wins.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (which would infer a latch).
        grant = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            sum = {1'b0, last} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (IDX_W+1)'(NUM_REQ);
            end
            idx = sum[IDX_W-1:0];
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tile_scheduler.sv
// Tile scheduler: walks a triangle's tile bounding box in raster order,
// dispatches each tile round-robin to NUM_EVAL evaluators, tracks tiles in
// flight and pulses tri_done once all of them have reported back.
// Optional performance counters are built when TILE_SCHED_PERF_EN is defined.
module tile_scheduler
    import tile_pkg::*;
#(
    parameter int COORD_W  = TILE_COORD_W,
    parameter int NUM_EVAL = 2,
    parameter int TRI_ID_W = 8
) (
    input  logic        clk,
    input  logic        rst,
`ifdef TILE_SCHED_PERF_EN
    input  logic        perf_clr,
    output logic [31:0] perf_tiles,
    output logic [31:0] perf_stall,
`endif
    tile_scheduler_if.slave bus
);

    localparam int IDX_W = (NUM_EVAL > 1) ? $clog2(NUM_EVAL) : 1;
    localparam int OUT_W = $clog2(NUM_EVAL + 2);

    state_t              state, state_d;
    logic [COORD_W-1:0]  min_x, min_x_d, max_x, max_x_d, max_y, max_y_d;
    logic [COORD_W-1:0]  cur_x, cur_x_d, cur_y, cur_y_d;
    logic [TRI_ID_W-1:0] tag, tag_d;
    logic                more, more_d;
    logic [NUM_EVAL-1:0] valid_q, valid_d;
    logic [COORD_W-1:0]  tile_x_q, tile_x_d, tile_y_q, tile_y_d;
    logic [TRI_ID_W-1:0] tile_id_q, tile_id_d;
    logic [IDX_W-1:0]    rr_ptr, rr_ptr_d;
    logic [OUT_W-1:0]    outstanding, outstanding_d;
    logic                done_q, done_d;
    logic [TRI_ID_W-1:0] done_id_q, done_id_d;

    logic [NUM_EVAL-1:0] grant;
    logic [IDX_W-1:0]    grant_idx;
    logic                hs;
    logic                slot_free;
    logic                last_tile;
    logic [MAX_EVAL-1:0] done_ext;
    logic [OUT_W:0]      out_sum;
    logic [OUT_W:0]      done_cnt;

    rr_arbiter #(
        .NUM_REQ (NUM_EVAL),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req   (bus.disp_ready),
        .last  (rr_ptr),
        .grant (grant)
    );

    assign hs        = |(valid_q & bus.disp_ready);
    assign slot_free = (valid_q == '0) || hs;
    assign last_tile = (cur_x == max_x) && (cur_y == max_y);

    // Encode the one-hot grant as the new round-robin pointer value.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_EVAL; i++) begin
            if (grant[i]) grant_idx = IDX_W'(i);
        end
    end

    // In-flight count: +1 per handshake, minus done pulses, floored at zero.
    always_comb begin
        done_ext                 = '0;
        done_ext[NUM_EVAL-1:0]   = bus.eval_done;
        done_cnt                 = (OUT_W+1)'(popcount(done_ext));
        out_sum                  = {1'b0, outstanding} + (OUT_W+1)'(hs);
        if (done_cnt >= out_sum) outstanding_d = '0;
        else                     outstanding_d = OUT_W'(out_sum - done_cnt);
    end

    // Next-state and next-output logic for the traversal FSM.
    always_comb begin
        state_d   = state;
        min_x_d   = min_x;
        max_x_d   = max_x;
        max_y_d   = max_y;
        cur_x_d   = cur_x;
        cur_y_d   = cur_y;
        tag_d     = tag;
        more_d    = more;
        valid_d   = valid_q;
        tile_x_d  = tile_x_q;
        tile_y_d  = tile_y_q;
        tile_id_d = tile_id_q;
        rr_ptr_d  = rr_ptr;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        case (state)
            IDLE: begin
                if (bus.tri_valid) begin
                    min_x_d = bus.bb_min_x;
                    max_x_d = bus.bb_max_x;
                    max_y_d = bus.bb_max_y;
                    cur_x_d = bus.bb_min_x;
                    cur_y_d = bus.bb_min_y;
                    tag_d   = bus.tri_id;
                    if (bus.bb_min_x > bus.bb_max_x || bus.bb_min_y > bus.bb_max_y) begin
                        more_d  = 1'b0;
                        state_d = DRAIN;
                    end else begin
                        more_d  = 1'b1;
                        state_d = DISPATCH;
                    end
                end
            end
            DISPATCH: begin
                // An unaccepted offer holds; only a free slot can change the bus.
                if (slot_free) begin
                    if (more) begin
                        if (grant != '0) begin
                            valid_d   = grant;
                            tile_x_d  = cur_x;
                            tile_y_d  = cur_y;
                            tile_id_d = tag;
                            rr_ptr_d  = grant_idx;
                            // Equality end-test: the counter is never stepped past the box.
                            if (last_tile) begin
                                more_d = 1'b0;
                            end else if (cur_x == max_x) begin
                                cur_x_d = min_x;
                                cur_y_d = cur_y + COORD_W'(1);
                            end else begin
                                cur_x_d = cur_x + COORD_W'(1);
                            end
                        end else begin
                            valid_d = '0;
                        end
                    end else begin
                        valid_d = '0;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (outstanding_d == '0) begin
                    done_d    = 1'b1;
                    done_id_d = tag;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Datapath and registered outputs; reset abandons any triangle silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_x       <= '0;
            max_x       <= '0;
            max_y       <= '0;
            cur_x       <= '0;
            cur_y       <= '0;
            tag         <= '0;
            more        <= 1'b0;
            valid_q     <= '0;
            tile_x_q    <= '0;
            tile_y_q    <= '0;
            tile_id_q   <= '0;
            rr_ptr      <= IDX_W'(NUM_EVAL - 1);
            outstanding <= '0;
            done_q      <= 1'b0;
            done_id_q   <= '0;
        end else begin
            min_x       <= min_x_d;
            max_x       <= max_x_d;
            max_y       <= max_y_d;
            cur_x       <= cur_x_d;
            cur_y       <= cur_y_d;
            tag         <= tag_d;
            more        <= more_d;
            valid_q     <= valid_d;
            tile_x_q    <= tile_x_d;
            tile_y_q    <= tile_y_d;
            tile_id_q   <= tile_id_d;
            rr_ptr      <= rr_ptr_d;
            outstanding <= outstanding_d;
            done_q      <= done_d;
            done_id_q   <= done_id_d;
        end
    end

    assign bus.tri_ready   = (state == IDLE);
    assign bus.busy        = (state != IDLE);
    assign bus.disp_valid  = valid_q;
    assign bus.disp_tile_x = tile_x_q;
    assign bus.disp_tile_y = tile_y_q;
    assign bus.disp_tri_id = tile_id_q;
    assign bus.tri_done    = done_q;
    assign bus.tri_done_id = done_id_q;

`ifdef TILE_SCHED_PERF_EN
    logic stall_cycle;
    assign stall_cycle = (state == DISPATCH) && more && (valid_q == '0);

    // Saturating performance counters; a clear takes priority over counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_tiles <= '0;
            perf_stall <= '0;
        end else if (perf_clr) begin
            perf_tiles <= '0;
            perf_stall <= '0;
        end else begin
            if (hs && perf_tiles != '1)          perf_tiles <= perf_tiles + 32'd1;
            if (stall_cycle && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tile_scheduler.sv
// Directed testbench for tile_scheduler: raster walk, round-robin choice,
// offer hold, degenerate and edge-of-range boxes, outstanding tracking
// and asynchronous reset abort.
module tb_tile_scheduler;

    localparam int COORD_W  = 10;
    localparam int NUM_EVAL = 2;
    localparam int TRI_ID_W = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    tile_scheduler_if #(
        .COORD_W  (COORD_W),
        .NUM_EVAL (NUM_EVAL),
        .TRI_ID_W (TRI_ID_W)
    ) bus ();

`ifdef TILE_SCHED_PERF_EN
    logic        perf_clr;
    logic [31:0] perf_tiles;
    logic [31:0] perf_stall;
    initial perf_clr = 1'b0;
`endif

    tile_scheduler #(
        .COORD_W  (COORD_W),
        .NUM_EVAL (NUM_EVAL),
        .TRI_ID_W (TRI_ID_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef TILE_SCHED_PERF_EN
        .perf_clr   (perf_clr),
        .perf_tiles (perf_tiles),
        .perf_stall (perf_stall),
`endif
        .bus        (bus.slave)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a bbox for exactly one accepting edge.
    task automatic offer(input logic [7:0] id, input logic [9:0] x0, input logic [9:0] y0,
                         input logic [9:0] x1, input logic [9:0] y1);
        bus.tri_valid = 1'b1;
        bus.tri_id    = id;
        bus.bb_min_x  = x0;
        bus.bb_min_y  = y0;
        bus.bb_max_x  = x1;
        bus.bb_max_y  = y1;
        step();
        bus.tri_valid = 1'b0;
    endtask

    task automatic test_reset();
        step();
        step();
        checks++;
        if ({bus.tri_ready, bus.busy, bus.disp_valid, bus.tri_done} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 10000", {bus.tri_ready, bus.busy, bus.disp_valid, bus.tri_done});
        end
        checks++;
        if ({bus.disp_tile_x, bus.disp_tile_y, bus.disp_tri_id, bus.tri_done_id} !== 36'h0) begin
            errors++;
            $display("FAIL reset_bus: got %h expected 0", {bus.disp_tile_x, bus.disp_tile_y, bus.disp_tri_id, bus.tri_done_id});
        end
        rst = 1'b0;
        step();
        checks++;
        if ({bus.tri_ready, bus.busy, bus.disp_valid} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_release: got %b expected 1000", {bus.tri_ready, bus.busy, bus.disp_valid});
        end
    endtask

    task automatic test_basic();
        logic [1:0] ev [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [9:0] ex [4] = '{10'd2, 10'd3, 10'd2, 10'd3};
        logic [9:0] ey [4] = '{10'd3, 10'd3, 10'd4, 10'd4};
        bus.disp_ready = 2'b11;
        offer(8'hA1, 10'd2, 10'd3, 10'd3, 10'd4);
        checks++;
        if ({bus.busy, bus.tri_ready, bus.disp_valid} !== 4'b1000) begin
            errors++;
            $display("FAIL basic_accept: got %b expected 1000", {bus.busy, bus.tri_ready, bus.disp_valid});
        end
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if ({bus.disp_valid, bus.disp_tile_x, bus.disp_tile_y, bus.disp_tri_id} !== {ev[k], ex[k], ey[k], 8'hA1}) begin
                errors++;
                $display("FAIL basic_tile%0d: got v=%b x=%0d y=%0d id=%h expected v=%b x=%0d y=%0d id=a1",
                         k, bus.disp_valid, bus.disp_tile_x, bus.disp_tile_y, bus.disp_tri_id, ev[k], ex[k], ey[k]);
            end
            if (k > 0) bus.eval_done = ev[k-1];
            else       bus.eval_done = 2'b00;
        end
        step();
        checks++;
        if ({bus.disp_valid, bus.tri_done, bus.busy} !== 4'b0001) begin
            errors++;
            $display("FAIL basic_drain: got %b expected 0001", {bus.disp_valid, bus.tri_done, bus.busy});
        end
        bus.eval_done = ev[3];
        step();
        bus.eval_done = 2'b00;
        checks++;
        if ({bus.tri_done, bus.tri_done_id, bus.busy} !== {1'b1, 8'hA1, 1'b0}) begin
            errors++;
            $display("FAIL basic_done: got done=%b id=%h busy=%b expected done=1 id=a1 busy=0", bus.tri_done, bus.tri_done_id, bus.busy);
        end
        step();
        checks++;
        if (bus.tri_done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: got %b expected 0", bus.tri_done);
        end
    endtask

    task automatic test_same_cycle();
        bus.disp_ready = 2'b01;
        offer(8'h42, 10'd0, 10'd0, 10'd1, 10'd0);
        step();
        checks++;
        if ({bus.disp_valid, bus.disp_tile_x, bus.disp_tile_y} !== {2'b01, 10'd0, 10'd0}) begin
            errors++;
            $display("FAIL same_tile0: got v=%b x=%0d y=%0d expected v=01 x=0 y=0", bus.disp_valid, bus.disp_tile_x, bus.disp_tile_y);
        end
        step();
        checks++;
        if ({bus.disp_valid, bus.disp_tile_x, bus.disp_tile_y} !== {2'b01, 10'd1, 10'd0}) begin
            errors++;
            $display("FAIL same_tile1: got v=%b x=%0d y=%0d expected v=01 x=1 y=0", bus.disp_valid, bus.disp_tile_x, bus.disp_tile_y);
        end
        bus.eval_done = 2'b01;
        step();
        bus.eval_done = 2'b00;
        checks++;
        if ({bus.disp_valid, bus.tri_done} !== 3'b000) begin
            errors++;
            $display("FAIL same_hs_done: got %b expected 000", {bus.disp_valid, bus.tri_done});
        end
        step();
        checks++;
        if ({bus.tri_done, bus.busy} !== 2'b01) begin
            errors++;
            $display("FAIL same_wait: got %b expected 01", {bus.tri_done, bus.busy});
        end
        bus.eval_done = 2'b01;
        step();
        bus.eval_done = 2'b00;
        checks++;
        if ({bus.tri_done, bus.tri_done_id} !== {1'b1, 8'h42}) begin
            errors++;
            $display("FAIL same_done: got done=%b id=%h expected done=1 id=42", bus.tri_done, bus.tri_done_id);
        end
    endtask

    task automatic test_degenerate();
        // Stray done pulses while idle must not disturb the in-flight count.
        bus.eval_done = 2'b11;
        step();
        bus.eval_done = 2'b00;
        offer(8'h5C, 10'd5, 10'd0, 10'd4, 10'd0);
        checks++;
        if ({bus.busy, bus.disp_valid, bus.tri_done} !== 4'b1000) begin
            errors++;
            $display("FAIL degen_accept: got %b expected 1000", {bus.busy, bus.disp_valid, bus.tri_done});
        end
        step();
        checks++;
        if ({bus.tri_done, bus.tri_done_id, bus.disp_valid} !== {1'b1, 8'h5C, 2'b00}) begin
            errors++;
            $display("FAIL degen_done: got done=%b id=%h v=%b expected done=1 id=5c v=00", bus.tri_done, bus.tri_done_id, bus.disp_valid);
        end
        step();
        checks++;
        if ({bus.tri_done, bus.disp_valid} !== 3'b000) begin
            errors++;
            $display("FAIL degen_after: got %b expected 000", {bus.tri_done, bus.disp_valid});
        end
    endtask

    task automatic test_single_eval();
        logic [9:0] ex [3] = '{10'd4, 10'd5, 10'd6};
        bus.disp_ready = 2'b01;
        offer(8'h33, 10'd4, 10'd7, 10'd6, 10'd7);
        step();
        checks++;
        if ({bus.disp_valid, bus.disp_tile_x, bus.disp_tile_y} !== {2'b01, 10'd4, 10'd7}) begin
            errors++;
            $display("FAIL single_first: got v=%b x=%0d y=%0d expected v=01 x=4 y=7", bus.disp_valid, bus.disp_tile_x, bus.disp_tile_y);
        end
        bus.disp_ready = 2'b00;
        for (int h = 0; h < 2; h++) begin
            step();
            checks++;
            if ({bus.disp_valid, bus.disp_tile_x, bus.disp_tile_y, bus.disp_tri_id} !== {2'b01, 10'd4, 10'd7, 8'h33}) begin
                errors++;
                $display("FAIL single_hold%0d: got v=%b x=%0d y=%0d id=%h expected v=01 x=4 y=7 id=33",
                         h, bus.disp_valid, bus.disp_tile_x, bus.disp_tile_y, bus.disp_tri_id);
            end
        end
        bus.disp_ready = 2'b01;
        for (int k = 1; k < 3; k++) begin
            step();
            checks++;
            if ({bus.disp_valid, bus.disp_tile_x, bus.disp_tile_y} !== {2'b01, ex[k], 10'd7}) begin
                errors++;
                $display("FAIL single_tile%0d: got v=%b x=%0d y=%0d expected v=01 x=%0d y=7",
                         k, bus.disp_valid, bus.disp_tile_x, bus.disp_tile_y, ex[k]);
            end
        end
        step();
        checks++;
        if ({bus.disp_valid, bus.tri_done} !== 3'b000) begin
            errors++;
            $display("FAIL single_drain: got %b expected 000", {bus.disp_valid, bus.tri_done});
        end
        for (int j = 0; j < 3; j++) begin
            bus.eval_done = 2'b01;
            step();
            bus.eval_done = 2'b00;
            checks++;
            if (bus.tri_done !== (j == 2)) begin
                errors++;
                $display("FAIL single_done%0d: got %b expected %b", j, bus.tri_done, (j == 2));
            end
        end
    endtask

    task automatic test_max_coord();
        logic [1:0] ev [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
        logic [9:0] ex [4] = '{10'd1022, 10'd1023, 10'd1022, 10'd1023};
        logic [9:0] ey [4] = '{10'd1022, 10'd1022, 10'd1023, 10'd1023};
        bus.disp_ready = 2'b11;
        offer(8'h7E, 10'd1022, 10'd1022, 10'd1023, 10'd1023);
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if ({bus.disp_valid, bus.disp_tile_x, bus.disp_tile_y} !== {ev[k], ex[k], ey[k]}) begin
                errors++;
                $display("FAIL max_tile%0d: got v=%b x=%0d y=%0d expected v=%b x=%0d y=%0d",
                         k, bus.disp_valid, bus.disp_tile_x, bus.disp_tile_y, ev[k], ex[k], ey[k]);
            end
            if (k > 0) bus.eval_done = ev[k-1];
            else       bus.eval_done = 2'b00;
        end
        step();
        checks++;
        if ({bus.disp_valid, bus.busy} !== 3'b001) begin
            errors++;
            $display("FAIL max_no_wrap: got %b expected 001", {bus.disp_valid, bus.busy});
        end
        bus.eval_done = ev[3];
        step();
        bus.eval_done = 2'b00;
        checks++;
        if ({bus.tri_done, bus.tri_done_id} !== {1'b1, 8'h7E}) begin
            errors++;
            $display("FAIL max_done: got done=%b id=%h expected done=1 id=7e", bus.tri_done, bus.tri_done_id);
        end
    endtask

    task automatic test_reset_mid();
        int done_seen;
        bus.disp_ready = 2'b11;
        offer(8'h99, 10'd0, 10'd0, 10'd3, 10'd3);
        step();
        step();
        checks++;
        if ({bus.disp_valid, bus.disp_tile_x, bus.disp_tile_y} !== {2'b01, 10'd1, 10'd0}) begin
            errors++;
            $display("FAIL abort_pre: got v=%b x=%0d y=%0d expected v=01 x=1 y=0", bus.disp_valid, bus.disp_tile_x, bus.disp_tile_y);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.disp_valid, bus.disp_tile_x, bus.disp_tile_y, bus.disp_tri_id} !== 30'h0) begin
            errors++;
            $display("FAIL abort_async_bus: got %h expected 0", {bus.disp_valid, bus.disp_tile_x, bus.disp_tile_y, bus.disp_tri_id});
        end
        checks++;
        if ({bus.tri_ready, bus.busy, bus.tri_done, bus.tri_done_id} !== {3'b100, 8'h00}) begin
            errors++;
            $display("FAIL abort_async_ctrl: got %b expected 10000000000", {bus.tri_ready, bus.busy, bus.tri_done, bus.tri_done_id});
        end
        step();
        rst = 1'b0;
        done_seen = 0;
        bus.eval_done = 2'b11;
        for (int c = 0; c < 6; c++) begin
            step();
            bus.eval_done = 2'b00;
            if (bus.tri_done) done_seen++;
        end
        checks++;
        if ({bus.tri_ready, 32'(done_seen)} !== {1'b1, 32'd0}) begin
            errors++;
            $display("FAIL abort_no_done: got ready=%b dones=%0d expected ready=1 dones=0", bus.tri_ready, done_seen);
        end
        offer(8'h11, 10'd9, 10'd9, 10'd9, 10'd9);
        step();
        checks++;
        if ({bus.disp_valid, bus.disp_tile_x, bus.disp_tile_y, bus.disp_tri_id} !== {2'b01, 10'd9, 10'd9, 8'h11}) begin
            errors++;
            $display("FAIL abort_rr_restart: got v=%b x=%0d y=%0d id=%h expected v=01 x=9 y=9 id=11",
                     bus.disp_valid, bus.disp_tile_x, bus.disp_tile_y, bus.disp_tri_id);
        end
        step();
        bus.eval_done = 2'b01;
        step();
        bus.eval_done = 2'b00;
        checks++;
        if ({bus.tri_done, bus.tri_done_id} !== {1'b1, 8'h11}) begin
            errors++;
            $display("FAIL abort_next_done: got done=%b id=%h expected done=1 id=11", bus.tri_done, bus.tri_done_id);
        end
    endtask

    initial begin
        rst            = 1'b1;
        bus.tri_valid  = 1'b0;
        bus.tri_id     = '0;
        bus.bb_min_x   = '0;
        bus.bb_min_y   = '0;
        bus.bb_max_x   = '0;
        bus.bb_max_y   = '0;
        bus.disp_ready = '0;
        bus.eval_done  = '0;
        test_reset();
        test_basic();
        test_same_cycle();
        test_degenerate();
        test_single_eval();
        test_max_coord();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
